sad_min_tracker: RTL
====================

Name: sad_min_tracker

Overview:
- Downstream consumer of the 32x32 PE array's absolute-difference output (1024 x 8-bit per search position).
- Reduces each abs array in a fully pipelined tree to 21 partition SADs: sixteen 8x8, four 16x16 and one 32x32.
- Tracks the minimum SAD and its motion vector per partition across one search round.
- Presents registered best results to the mode-decision stage, one result set per CU search.

Parameters:
- PIXEL, 8, abs sample width.
- MV_W, 7, signed width of each MV component (search range -64..+63).
- SAD8_W, 14, 8x8 SAD width (max 64*255 = 16320).
- SAD16_W, 16, 16x16 SAD width (max 65280).
- SAD32_W, 18, 32x32 SAD width (max 261120).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-high
- abs_valid  in  1  abs_in and tags valid this cycle
- abs_in  in  8192  abs value of pixel (r,c) at bits [(32*r+c)*8 +: 8]; r=0 is north row, c=0 is west column
- mv_x  in  MV_W  signed horizontal MV of this search position
- mv_y  in  MV_W  signed vertical MV of this search position
- search_start  in  1  first position of a new CU search; qualified by abs_valid
- search_last  in  1  last position of the search; qualified by abs_valid
- best_sad8  out  16*SAD8_W  block b=4*by+bx at [b*SAD8_W +: SAD8_W]
- best_mv8  out  16*2*MV_W  block b at [b*14 +: 14], packed {mv_y, mv_x}
- best_sad16  out  4*SAD16_W  quadrant q=2*qy+qx
- best_mv16  out  4*2*MV_W  same packing as best_mv8
- best_sad32  out  SAD32_W  whole CU
- best_mv32  out  2*MV_W  {mv_y, mv_x}
- result_valid  out  1  one-cycle pulse; result outputs are new
- busy  out  1  any pipeline stage holds a valid position

Behaviour:
- Pipeline with tags {valid, start, last, mv} carried alongside data:
  - P1: 128 row sums, each 8 pixels wide (11b).
  - P2: 16 8x8 SADs.
  - P3: 4 16x16 SADs (8x8 passed through).
  - P4: 32x32 SAD (others passed through).
  - All adds are zero-extended unsigned; no saturation needed since the widths cover the maximum.
- Compare/update at the edge after P4 is valid. Per partition:
  - If tag start = 1: best <= current unconditionally.
  - Else if current < best (strict): best <= current. On ties the earliest position wins.
- Latency: position sampled at edge k. Best registers reflect it after edge k+4.
  - If tag last = 1, the result registers load the post-update best values at edge k+4.
  - result_valid is high for exactly the cycle following edge k+4.
- Result outputs hold their value until the next result_valid. They are not disturbed by a search in progress.
- abs_valid = 0 inserts a bubble. start and last are ignored when abs_valid = 0. Bubbles never update best registers.
- start and last both set on the same position gives a single-position search; that position's SAD and MV are the result.
- Back-to-back searches are allowed: a new start may immediately follow the previous last. The previous result pulses first and is unaffected.
- If a position arrives without a prior start, it compares against the current best registers. After reset these are all-ones SAD and MV 0.
- busy = OR of the P1..P4 valid bits.
- Reset, including mid-operation: all pipeline valids cleared and in-flight positions discarded.
  - Best SADs set to all-ones, best MVs set to 0.
  - Result outputs set to 0, result_valid = 0, busy = 0.

Decomposition:
- Package sad_pkg holds PIXEL, MV_W, the SAD widths, the block-index and MV packing helper functions, and a MV typedef {mv_y, mv_x}.
- Sub-module sad_best_tracker: compare-and-hold for one partition, parameterized by SAD width, with start/valid inputs. Instantiated 21 times.

Test Plan:
- All abs = 1, mv = (3,-2), start and last set -> result_valid in the cycle after edge k+4.
  - Expect every sad8 = 64, sad16 = 256, sad32 = 1024, every mv = {-2,3}.
- All abs = 255, single position -> sad8 = 16320, sad16 = 65280, sad32 = 261120 (no overflow).
- Three positions with sad32 = 900, 500, 700 -> best_sad32 = 500 with the second position's MV.
  - Block 5 only set lowest on the third position -> best_mv8[5] is the third MV while best_mv32 stays the second.
- Tie: positions 1 and 2 both with sad32 = 400 -> position 1's MV retained.
- Bubbles between positions, then start of search B on the cycle after last of A -> two result pulses 1+bubbles apart.
  - Search A's results are unaffected by B.
- Assert rst while 3 positions are in flight -> no result_valid, busy = 0 next cycle, outputs 0.
  - A following single-position search is correct.

Source files
------------

// File: rtl/sad_pkg.sv
// Shared widths, tag/MV types and index helpers for the SAD minimum tracker.
package sad_pkg;

  localparam int unsigned PIXEL    = 8;
  localparam int unsigned MV_W     = 7;
  localparam int unsigned SAD8_W   = 14;
  localparam int unsigned SAD16_W  = 16;
  localparam int unsigned SAD32_W  = 18;

  localparam int unsigned CU_DIM   = 32;
  localparam int unsigned ROW_W    = 11;
  localparam int unsigned SEGS     = 4;
  localparam int unsigned NROW     = CU_DIM * SEGS;
  localparam int unsigned N8       = 16;
  localparam int unsigned N16      = 4;

  typedef struct packed {
    logic signed [MV_W-1:0] mv_y;
    logic signed [MV_W-1:0] mv_x;
  } mv_t;

  typedef struct packed {
    logic valid;
    logic start;
    logic last;
    mv_t  mv;
  } tag_t;

  // 8x8 block index within the CU, raster order north-west first
  function automatic int unsigned blk8_idx(input int unsigned by, input int unsigned bx);
    return 4 * by + bx;
  endfunction

  // 16x16 quadrant index within the CU
  function automatic int unsigned blk16_idx(input int unsigned qy, input int unsigned qx);
    return 2 * qy + qx;
  endfunction

  function automatic mv_t pack_mv(input logic signed [MV_W-1:0] x,
                                  input logic signed [MV_W-1:0] y);
    mv_t m;
    m.mv_y = y;
    m.mv_x = x;
    return m;
  endfunction

endpackage

// File: rtl/sad_best_tracker.sv
// Compare-and-hold of the best SAD/MV for one partition over a search round.
module sad_best_tracker
  import sad_pkg::*;
#(
  parameter int unsigned SAD_W = SAD8_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_i,
  input  logic             start_i,
  input  logic [SAD_W-1:0] cur_sad_i,
  input  mv_t              cur_mv_i,
  output logic [SAD_W-1:0] upd_sad_o,
  output mv_t              upd_mv_o
);

  logic [SAD_W-1:0] best_sad_q;
  mv_t              best_mv_q;
  logic             take;

  // Post-update best: start overrides, otherwise strict less-than keeps the earliest tie
  always_comb begin
    take      = valid_i && (start_i || (cur_sad_i < best_sad_q));
    upd_sad_o = take ? cur_sad_i : best_sad_q;
    upd_mv_o  = take ? cur_mv_i  : best_mv_q;
  end

  // Best registers; reset to worst possible SAD with a zero vector
  always_ff @(posedge clk) begin
    if (rst) begin
      best_sad_q <= '1;
      best_mv_q  <= '0;
    end else begin
      best_sad_q <= upd_sad_o;
      best_mv_q  <= upd_mv_o;
    end
  end

endmodule

// File: rtl/sad_min_tracker.sv
// Pipelined 32x32 abs-difference reduction to 21 partition SADs with
// per-partition minimum tracking and registered per-search results.
module sad_min_tracker
  import sad_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          abs_valid,
  input  logic [CU_DIM*CU_DIM*PIXEL-1:0] abs_in,
  input  logic signed [MV_W-1:0]        mv_x,
  input  logic signed [MV_W-1:0]        mv_y,
  input  logic                          search_start,
  input  logic                          search_last,
  output logic [N8*SAD8_W-1:0]          best_sad8,
  output logic [N8*2*MV_W-1:0]          best_mv8,
  output logic [N16*SAD16_W-1:0]        best_sad16,
  output logic [N16*2*MV_W-1:0]         best_mv16,
  output logic [SAD32_W-1:0]            best_sad32,
  output logic [2*MV_W-1:0]             best_mv32,
  output logic                          result_valid,
  output logic                          busy
);

  tag_t               tag_in;
  tag_t               tag_q [4];

  logic [ROW_W-1:0]   row_d   [NROW];
  logic [ROW_W-1:0]   row_q   [NROW];
  logic [SAD8_W-1:0]  s8_d    [N8];
  logic [SAD8_W-1:0]  s8_q    [N8];
  logic [SAD8_W-1:0]  s8p3_q  [N8];
  logic [SAD8_W-1:0]  s8p4_q  [N8];
  logic [SAD16_W-1:0] s16_d   [N16];
  logic [SAD16_W-1:0] s16_q   [N16];
  logic [SAD16_W-1:0] s16p4_q [N16];
  logic [SAD32_W-1:0] s32_d;
  logic [SAD32_W-1:0] s32_q;

  logic [SAD8_W-1:0]  n8_sad  [N8];
  mv_t                n8_mv   [N8];
  logic [SAD16_W-1:0] n16_sad [N16];
  mv_t                n16_mv  [N16];
  logic [SAD32_W-1:0] n32_sad;
  mv_t                n32_mv;

  logic [N8*SAD8_W-1:0]   res_sad8_q;
  logic [N8*2*MV_W-1:0]   res_mv8_q;
  logic [N16*SAD16_W-1:0] res_sad16_q;
  logic [N16*2*MV_W-1:0]  res_mv16_q;
  logic [SAD32_W-1:0]     res_sad32_q;
  logic [2*MV_W-1:0]      res_mv32_q;
  logic                   res_valid_q;
  logic                   load_res;

  // Incoming tag; start/last only mean something on a valid position
  always_comb begin
    tag_in       = '0;
    tag_in.valid = abs_valid;
    tag_in.start = abs_valid & search_start;
    tag_in.last  = abs_valid & search_last;
    tag_in.mv    = pack_mv(mv_x, mv_y);
  end

  // Tag pipeline P1..P4; reset discards any in-flight positions
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < 4; i++) tag_q[i] <= '0;
    end else begin
      tag_q[0] <= tag_in;
      for (int unsigned i = 1; i < 4; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  // P1 adder: 8-pixel row segment sums, segment s covers columns 8s..8s+7
  always_comb begin
    for (int unsigned r = 0; r < CU_DIM; r++) begin
      for (int unsigned s = 0; s < SEGS; s++) begin
        row_d[r*SEGS+s] = '0;
        for (int unsigned c = 0; c < 8; c++) begin
          row_d[r*SEGS+s] = row_d[r*SEGS+s]
                          + ROW_W'(abs_in[(CU_DIM*r + 8*s + c)*PIXEL +: PIXEL]);
        end
      end
    end
  end

  // P2 adder: 8x8 SAD from eight vertically stacked row segments
  always_comb begin
    for (int unsigned by = 0; by < 4; by++) begin
      for (int unsigned bx = 0; bx < 4; bx++) begin
        s8_d[blk8_idx(by, bx)] = '0;
        for (int unsigned r = 0; r < 8; r++) begin
          s8_d[blk8_idx(by, bx)] = s8_d[blk8_idx(by, bx)]
                                 + SAD8_W'(row_q[(8*by + r)*SEGS + bx]);
        end
      end
    end
  end

  // P3 adder: 16x16 SAD from its four 8x8 blocks
  always_comb begin
    for (int unsigned qy = 0; qy < 2; qy++) begin
      for (int unsigned qx = 0; qx < 2; qx++) begin
        s16_d[blk16_idx(qy, qx)] = '0;
        for (int unsigned i = 0; i < 2; i++) begin
          for (int unsigned j = 0; j < 2; j++) begin
            s16_d[blk16_idx(qy, qx)] = s16_d[blk16_idx(qy, qx)]
                                     + SAD16_W'(s8_q[blk8_idx(2*qy + i, 2*qx + j)]);
          end
        end
      end
    end
  end

  // P4 adder: whole-CU SAD from the four quadrants
  always_comb begin
    s32_d = '0;
    for (int unsigned q = 0; q < N16; q++) s32_d = s32_d + SAD32_W'(s16_q[q]);
  end

  // Datapath stage registers; contents are qualified by the tag valid bits
  always_ff @(posedge clk) begin
    row_q   <= row_d;
    s8_q    <= s8_d;
    s8p3_q  <= s8_q;
    s16_q   <= s16_d;
    s8p4_q  <= s8p3_q;
    s16p4_q <= s16_q;
    s32_q   <= s32_d;
  end

  for (genvar g = 0; g < N8; g++) begin : g_trk8
    sad_best_tracker #(.SAD_W(SAD8_W)) u_trk (
      .clk       (clk),
      .rst       (rst),
      .valid_i   (tag_q[3].valid),
      .start_i   (tag_q[3].start),
      .cur_sad_i (s8p4_q[g]),
      .cur_mv_i  (tag_q[3].mv),
      .upd_sad_o (n8_sad[g]),
      .upd_mv_o  (n8_mv[g])
    );
  end

  for (genvar g = 0; g < N16; g++) begin : g_trk16
    sad_best_tracker #(.SAD_W(SAD16_W)) u_trk (
      .clk       (clk),
      .rst       (rst),
      .valid_i   (tag_q[3].valid),
      .start_i   (tag_q[3].start),
      .cur_sad_i (s16p4_q[g]),
      .cur_mv_i  (tag_q[3].mv),
      .upd_sad_o (n16_sad[g]),
      .upd_mv_o  (n16_mv[g])
    );
  end

  sad_best_tracker #(.SAD_W(SAD32_W)) u_trk32 (
    .clk       (clk),
    .rst       (rst),
    .valid_i   (tag_q[3].valid),
    .start_i   (tag_q[3].start),
    .cur_sad_i (s32_q),
    .cur_mv_i  (tag_q[3].mv),
    .upd_sad_o (n32_sad),
    .upd_mv_o  (n32_mv)
  );

  assign load_res = tag_q[3].valid & tag_q[3].last;

  // Result registers capture the post-update bests on the last position of a search
  always_ff @(posedge clk) begin
    if (rst) begin
      res_sad8_q  <= '0;
      res_mv8_q   <= '0;
      res_sad16_q <= '0;
      res_mv16_q  <= '0;
      res_sad32_q <= '0;
      res_mv32_q  <= '0;
      res_valid_q <= 1'b0;
    end else begin
      res_valid_q <= load_res;
      if (load_res) begin
        for (int unsigned g = 0; g < N8; g++) begin
          res_sad8_q[g*SAD8_W +: SAD8_W] <= n8_sad[g];
          res_mv8_q[g*2*MV_W +: 2*MV_W]  <= n8_mv[g];
        end
        for (int unsigned g = 0; g < N16; g++) begin
          res_sad16_q[g*SAD16_W +: SAD16_W] <= n16_sad[g];
          res_mv16_q[g*2*MV_W +: 2*MV_W]    <= n16_mv[g];
        end
        res_sad32_q <= n32_sad;
        res_mv32_q  <= n32_mv;
      end
    end
  end

  assign best_sad8    = res_sad8_q;
  assign best_mv8     = res_mv8_q;
  assign best_sad16   = res_sad16_q;
  assign best_mv16    = res_mv16_q;
  assign best_sad32   = res_sad32_q;
  assign best_mv32    = res_mv32_q;
  assign result_valid = res_valid_q;
  assign busy         = tag_q[0].valid | tag_q[1].valid | tag_q[2].valid | tag_q[3].valid;

endmodule
